// File: rtl/or_seq_pkg.sv
// Shared types and the golden OR-block truth function for the stimulus sequencer.
package or_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_PATTERNS = 16;

  // Returns {e, f, g} = {a|b|c|d, a|b, c|d} for idx = {a,b,c,d}.
  function automatic logic [2:0] expected_efg(input logic [3:0] idx);
    expected_efg = {|idx, |idx[3:2], |idx[1:0]};
  endfunction

endpackage

// File: rtl/or_stimulus_sequencer_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous level.
// pulse is high for one cycle; a consumer register acts on it at the third edge after din rises.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/or_stimulus_sequencer.sv
// Walks all 16 {a,b,c,d} patterns into the OR block, checks e/f/g at the end of each hold.
// Advance on hold expiry (mode=0) or on a synchronised step edge (mode=1); outputs are registered.
module or_stimulus_sequencer
  import or_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 20,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       step,
  input  logic       e_in,
  input  logic       f_in,
  input  logic       g_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] err_count
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(NUM_PATTERNS - 1);
  localparam logic [4:0]       ERR_MAX   = 5'(NUM_PATTERNS);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [4:0]       err_cnt_q, err_cnt_d;
  logic             step_pulse;
  logic             advance;
  logic             mismatch;

  edge_sync u_step_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (step),
    .pulse (step_pulse)
  );

  // Mode selects exactly one advance source, so a coincident step and expiry advance once.
  assign advance  = mode ? step_pulse : (cnt_q >= HOLD_LAST);
  assign mismatch = ({e_in, f_in, g_in} != expected_efg(idx_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          idx_d     = '0;
          cnt_d     = '0;
          err_cnt_d = '0;
        end
      end
      RUN: begin
        // Manual mode freezes the counter so a later switch to auto resumes where it paused.
        if (!mode) cnt_d = cnt_q + CNT_W'(1);
        if (advance) begin
          cnt_d = '0;
          if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q < ERR_MAX) err_cnt_d = err_cnt_q + 5'd1;
          end
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {a, b, c, d} = idx_q;
  assign idx          = idx_q;
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign err          = err_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_or_stimulus_sequencer.sv
// Randomised self-checking bench: OR-block model with injectable faults, reference timing
// derived from pattern number and hold length.
module tb_or_stimulus_sequencer;

  localparam int H = 4;

  logic       clk, rst, start, mode, step;
  logic       e_in, f_in, g_in;
  logic       a, b, c, d;
  logic [3:0] idx;
  logic       busy, done, err;
  logic [4:0] err_count;

  // Fault controls for the OR-block model: xor inverts, sm forces stuck-at-0; bit order {e,f,g}.
  logic [2:0] xm, sm;

  int total, bad;
  int exp_man;

  or_stimulus_sequencer #(.HOLD_CYCLES(H), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .step      (step),
    .e_in      (e_in),
    .f_in      (f_in),
    .g_in      (g_in),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .idx       (idx),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_count (err_count)
  );

  assign {e_in, f_in, g_in} = ({a | b | c | d, a | b, c | d} ^ xm) & ~sm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // True when pattern p would be flagged under the current fault settings.
  function automatic bit pat_bad(input int p);
    logic [3:0] v;
    logic [2:0] want, seen;
    v    = p[3:0];
    want = {(v != 4'd0), (v[3:2] != 2'd0), (v[1:0] != 2'd0)};
    seen = (want ^ xm) & ~sm;
    return seen != want;
  endfunction

  function automatic int count_bad(input int n);
    int s = 0;
    for (int p = 0; p < n; p++) if (pat_bad(p)) s++;
    return s;
  endfunction

  task automatic begin_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at a negedge with idx=first and the hold counter at 0, auto mode effective next edge.
  task automatic follow_auto(input int first, input bit rnd_start);
    int total_k, exp_idx, exp_c, pulses, seen_done;
    bit exp_done, exp_err;
    total_k = (NUM16() - first) * H;
    pulses  = 0;
    for (int k = 0; k <= total_k + 3; k++) begin
      if (k > 0) @(negedge clk);
      exp_done = (k >= total_k);
      exp_idx  = exp_done ? 15 : first + k / H;
      seen_done = (k / H > 16 - first) ? 16 - first : k / H;
      exp_c    = count_bad(first + seen_done);
      exp_err  = (k > 0) && (k % H == 0) && (k <= total_k) && pat_bad(first + k / H - 1);
      check_val("idx", 32'(idx), 32'(exp_idx));
      check_val("abcd", 32'({a, b, c, d}), 32'(exp_idx));
      check_val("busy", 32'(busy), 32'(!exp_done));
      check_val("done", 32'(done), 32'(exp_done));
      check_val("err", 32'(err), 32'(exp_err));
      check_val("err_count", 32'(err_count), 32'(exp_c));
      if (err) pulses++;
      start = (rnd_start && k < total_k) ? 1'($urandom % 2) : 1'b0;
    end
    check_val("err_pulses", 32'(pulses), 32'(count_bad(16) - count_bad(first)));
  endtask

  function automatic int NUM16();
    return 16;
  endfunction

  task automatic press(input int hold);
    step = 1'b1;
    for (int j = 1; j <= hold; j++) begin
      @(negedge clk);
      check_val("man_hold", 32'(idx), 32'((j >= 3) ? exp_man + 1 : exp_man));
    end
    exp_man++;
    step = 1'b0;
    for (int j = 0; j < 2 * H + 1; j++) begin
      @(negedge clk);
      check_val("man_gap", 32'(idx), 32'(exp_man));
      check_val("man_busy", 32'(busy), 32'd1);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    step  = 1'b0;
    xm    = 3'b000;
    sm    = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_idx", 32'(idx), 32'd0);
    check_val("rst_abcd", 32'({a, b, c, d}), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_val("idle_busy", 32'(busy), 32'd0);
    end

    // Clean auto run with start toggling during RUN.
    begin_run();
    follow_auto(0, 1'b1);

    // f stuck at 0: patterns 4..15 mismatch.
    sm = 3'b010;
    begin_run();
    follow_auto(0, 1'b1);
    check_val("f_stuck_cnt", 32'(err_count), 32'd12);

    // Random fault mixes; each restart from DONE must clear err_count.
    for (int r = 0; r < 4; r++) begin
      xm = 3'($urandom % 8);
      sm = 3'($urandom % 8);
      begin_run();
      follow_auto(0, 1'b1);
    end
    xm = 3'b000;
    sm = 3'b000;

    // Reset in the middle of pattern 7.
    begin_run();
    for (int k = 0; k < 7 * H + 2; k++) @(negedge clk);
    check_val("pre_rst_idx", 32'(idx), 32'd7);
    #2 rst = 1'b1;
    #1;
    check_val("async_idx", 32'(idx), 32'd0);
    check_val("async_abcd", 32'({a, b, c, d}), 32'd0);
    check_val("async_busy", 32'(busy), 32'd0);
    check_val("async_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin_run();
    follow_auto(0, 1'b0);

    // Manual stepping, then hand over to auto at idx 5.
    mode    = 1'b1;
    exp_man = 0;
    begin_run();
    check_val("man_start_idx", 32'(idx), 32'd0);
    for (int p = 0; p < 3; p++) press(int'($urandom_range(4, 12)));
    check_val("man_idx3", 32'(idx), 32'd3);
    check_val("man_abcd3", 32'({a, b, c, d}), 32'b0011);
    press(10);
    press(10);
    mode = 1'b0;
    follow_auto(5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/or_stimulus_sequencer.md
Name: or_stimulus_sequencer

Overview:
- Upstream stimulus stage for the four-input OR block.
- Walks all 16 combinations of a, b, c, d, with a as MSB and d as LSB. Each pattern is held for a fixed number of cycles.
- Samples the OR block's e, f, g outputs at the end of each hold and checks them against the expected values.
- Reports mismatch count and completion. It replaces the hand-written exhaustive stimulus list on board and in simulation.

Parameters:
- HOLD_CYCLES, 20, clock cycles each pattern is driven before it is sampled. Legal range is 2..65535.
- CNT_W, 16, width of the internal hold counter. Must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  level, synchronous to clk. Begins a run from IDLE or DONE.
- mode  input  1  0 = auto-advance after HOLD_CYCLES; 1 = manual, advance on step.
- step  input  1  raw push-button for manual advance. Asynchronous; synchronised internally.
- e_in  input  1  OR-block output e, expected a|b|c|d.
- f_in  input  1  OR-block output f, expected a|b.
- g_in  input  1  OR-block output g, expected c|d.
- a  output  1  stimulus bit 3 of idx.
- b  output  1  stimulus bit 2 of idx.
- c  output  1  stimulus bit 1 of idx.
- d  output  1  stimulus bit 0 of idx.
- idx  output  4  current pattern index.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- err  output  1  one-cycle pulse on a sampled mismatch.
- err_count  output  5  mismatches this run, 0..16, no wrap.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; a, b, c, d, idx=0; busy, done, err=0; err_count=0; hold counter=0; synchroniser flops=0.
- Outputs: {a,b,c,d} is always equal to idx and is registered. No combinational path from inputs to outputs.
- IDLE:
  - start=1 at a clock edge → RUN next cycle. idx=0, hold counter=0, err_count=0, busy=1.
- RUN, auto mode (mode=0):
  - The hold counter increments each cycle.
  - In the cycle the counter equals HOLD_CYCLES-1, e_in/f_in/g_in are sampled and compared with the expected values derived from the registered a..d.
  - On a mismatch: err pulses 1 in the next cycle and err_count increments in the same edge.
  - Same edge, idx<15: idx increments and the counter resets to 0. Each pattern is visible for exactly HOLD_CYCLES cycles.
  - Same edge, idx=15: → DONE. idx stays 15, busy=0, done=1.
- RUN, manual mode (mode=1):
  - The hold counter is ignored.
  - A rising edge of the synchronised step is detected 3 cycles after the raw step rise (2-FF synchroniser + edge register).
  - On that detected edge: sample/compare, then advance exactly as for the auto hold expiry.
  - A held step produces one advance only.
- Mode change: mode is sampled every cycle. Switching during RUN takes effect immediately; the hold counter is not cleared.
- start while in RUN: ignored. A run cannot be restarted without passing through DONE or reset.
- DONE:
  - done holds 1 and the outputs hold their final values. err_count is frozen.
  - start=1 → RUN with idx=0, done=0, err_count=0, same cycle timing as from IDLE.
- Simultaneous events:
  - Step edge and hold expiry in the same cycle: only one advance.
  - start and an advance in the same cycle: impossible by state, since start is ignored in RUN.
- Reset mid-run: immediate return to IDLE values; nothing from the partial run is retained.
- err_count saturates at 16, the maximum possible.

Decomposition:
- Package or_seq_pkg:
  - state enum {IDLE, RUN, DONE} with 2-bit encoding.
  - constant NUM_PATTERNS=16.
  - function expected_efg(idx) → 3 bits {a|b|c|d, a|b, c|d}.
- Sub-module edge_sync:
  - 2-FF synchroniser plus rising-edge detector.
  - Ports clk, rst, din, pulse.
  - One-cycle pulse output, 3-cycle latency.

Test Plan:
- Auto run, HOLD_CYCLES=4, e/f/g driven by a correct OR model:
  - idx steps 0..15 every 4 cycles.
  - done=1 at cycle 64 after RUN entry; err_count=0; err never pulses.
- Fault injection, f_in forced 0: mismatches at idx 4..15 → err_count=12 at DONE, one err pulse per affected pattern.
- Manual mode, 3 step presses, each held 10 cycles:
  - idx=3 and {a,b,c,d}=0011.
  - Each advance occurs 3 cycles after the press; no advance while held.
- Reset asserted at idx=7 mid-hold:
  - All outputs go to 0 without waiting for a clock edge.
  - After release, start restarts at idx=0.
- start pulsed repeatedly during RUN: no effect on idx or counter.
  - After DONE, start → new run with err_count cleared to 0.
- Mode switched from 1 to 0 at idx=5 with the counter paused: auto advance resumes; DONE still reached with idx=15.
